// File: rtl/snake_game_ctrl.sv
// Game controller around moving_snake: owns the committed snake body, paces moves
// with a step tick, and handles direction arbitration, food, growth, score and game over.
module snake_game_ctrl #(
  parameter int max_len         = 16,
  parameter int num_len         = 10,
  parameter int width           = 32,
  parameter int height          = 24,
  parameter int max_len_bit_len = 4,
  parameter int init_len        = 5,
  parameter int tick_div        = 25000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   di_req,
  input  logic                         di_req_valid,
  input  logic [max_len*num_len-1:0]   next_pos_num,
  input  logic                         should_stop,
  output logic [1:0]                   di,
  output logic [max_len_bit_len-1:0]   len,
  output logic [max_len*num_len-1:0]   pos_num,
  output logic [num_len-1:0]           food_pos,
  output logic [7:0]                   score,
  output logic [1:0]                   state,
  output logic                         step
);

  localparam int body_w    = max_len * num_len;
  localparam int tw        = (tick_div > 1) ? $clog2(tick_div) : 1;
  localparam int len_cap_i = (max_len < (1 << max_len_bit_len) - 1) ? max_len
                                                                   : (1 << max_len_bit_len) - 1;
  localparam logic [max_len_bit_len-1:0] len_cap   = max_len_bit_len'(len_cap_i);
  localparam logic [max_len_bit_len-1:0] len_init  = max_len_bit_len'(init_len);
  localparam logic [num_len-1:0]         food_init = num_len'(12 * width + 20);
  localparam logic [9:0]                 cells     = 10'(width * height);
  localparam logic [tw-1:0]              tick_last = tw'(tick_div - 1);

  function automatic logic [body_w-1:0] init_body();
    logic [body_w-1:0] b;
    b = '1;
    for (int i = 0; i < init_len; i++)
      b[i*num_len +: num_len] = num_len'(12 * width + init_len - 1 - i);
    return b;
  endfunction

  localparam logic [body_w-1:0] body_init = init_body();

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FOOD = 2'b10,
    S_OVER = 2'b11
  } state_t;

  state_t             st;
  logic [1:0]         pend;
  logic [tw-1:0]      tick;
  logic [9:0]         lfsr;
  logic               start_q;
  logic               start_rise;
  logic               req_ok;
  logic               self_hit;
  logic               food_hit;
  logic [9:0]         cand10;
  logic [num_len-1:0] cand;

  assign state      = st;
  assign start_rise = start & ~start_q;
  // di_req_valid is a one-cycle strobe with no ready: every strobe is sampled,
  // and a request reversing the current direction is silently dropped.
  assign req_ok     = di_req_valid && (di_req != {di[1], ~di[0]});

  assign cand10 = (lfsr < cells) ? lfsr : lfsr - cells;
  assign cand   = num_len'(cand10);

  always_comb begin
    self_hit = 1'b0;
    for (int k = 1; k < max_len; k++)
      if (k < int'(len) && next_pos_num[k*num_len +: num_len] == next_pos_num[0 +: num_len])
        self_hit = 1'b1;
  end

  always_comb begin
    food_hit = 1'b0;
    for (int i = 0; i < max_len; i++)
      if (i < int'(len) && pos_num[i*num_len +: num_len] == cand)
        food_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      di       <= 2'b01;
      pend     <= 2'b01;
      len      <= len_init;
      pos_num  <= body_init;
      food_pos <= food_init;
      score    <= 8'd0;
      step     <= 1'b0;
      tick     <= '0;
      lfsr     <= 10'h001;
      start_q  <= 1'b0;
    end else begin
      start_q <= start;
      lfsr    <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      step    <= 1'b0;
      if (st != S_OVER && req_ok)
        pend <= di_req;
      case (st)
        S_IDLE: begin
          tick <= '0;
          if (start_rise)
            st <= S_RUN;
        end
        S_RUN: begin
          if (tick == tick_last) begin
            tick <= '0;
            if (should_stop || self_hit) begin
              st <= S_OVER;
            end else begin
              // di takes the pend value from before any same-edge request.
              pos_num <= next_pos_num;
              di      <= pend;
              step    <= 1'b1;
              if (next_pos_num[0 +: num_len] == food_pos) begin
                if (len < len_cap)
                  len <= len + 1'b1;
                if (score != 8'hFF)
                  score <= score + 8'd1;
                st <= S_FOOD;
              end
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_FOOD: begin
          if (!food_hit) begin
            food_pos <= cand;
            st       <= S_RUN;
          end
        end
        S_OVER: begin
          if (start_rise) begin
            st       <= S_IDLE;
            di       <= 2'b01;
            pend     <= 2'b01;
            len      <= len_init;
            pos_num  <= body_init;
            food_pos <= food_init;
            score    <= 8'd0;
            tick     <= '0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: a moving_snake stand-in, a behavioural game model
// compared every cycle, directed scenarios with literal expectations, then random play.
module tb_snake_game_ctrl;
  localparam int ML = 16, NL = 10, W = 32, H = 24, LB = 4, IL = 5, TD = 4;
  localparam int CELLS = W * H, LEN_CAP = 15;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, di_req_valid = 1'b0;
  logic [1:0] di_req = 2'b00;
  logic [ML*NL-1:0] next_pos_num;
  logic should_stop;
  logic [1:0] di, state;
  logic [LB-1:0] len;
  logic [ML*NL-1:0] pos_num;
  logic [NL-1:0] food_pos;
  logic [7:0] score;
  logic step;

  int checks = 0, errors = 0, cyc = 0;
  int stamps[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  snake_game_ctrl #(.max_len(ML), .num_len(NL), .width(W), .height(H),
                    .max_len_bit_len(LB), .init_len(IL), .tick_div(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .di_req(di_req), .di_req_valid(di_req_valid),
    .next_pos_num(next_pos_num), .should_stop(should_stop), .di(di), .len(len),
    .pos_num(pos_num), .food_pos(food_pos), .score(score), .state(state), .step(step));

  // moving_snake stand-in: one registered step ahead of the committed body.
  always @(posedge clk or negedge rst_n) begin : env_ms
    int h, nh;
    logic stp;
    if (!rst_n) begin
      next_pos_num <= '1;
      should_stop  <= 1'b0;
    end else begin
      h = int'(pos_num[NL-1:0]);
      case (di)
        2'b00:   begin stp = (h % W == 0);     nh = h - 1; end
        2'b01:   begin stp = (h % W == W - 1); nh = h + 1; end
        2'b10:   begin stp = (h / W == 0);     nh = h - W; end
        default: begin stp = (h / W == H - 1); nh = h + W; end
      endcase
      next_pos_num <= {pos_num[(ML-1)*NL-1:0], NL'(nh)};
      should_stop  <= stp;
    end
  end

  // Behavioural model: phase 0 idle, 1 run, 2 food, 3 over.
  int m_phase, m_tick, m_di, m_pend, m_len, m_food, m_score, m_lfsr;
  int m_body[ML];
  bit m_step, m_start_q;

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int lfsr_next(input int l);
    return ((l * 2) % 1024) + (((l >> 9) ^ (l >> 6)) & 1);
  endfunction

  task automatic model_init(input bit full);
    m_phase = 0; m_tick = 0; m_di = 1; m_pend = 1; m_len = IL;
    m_food = 12 * W + 20; m_score = 0; m_step = 0;
    for (int i = 0; i < ML; i++) m_body[i] = (i < IL) ? 12 * W + IL - 1 - i : 1023;
    if (full) begin
      m_lfsr = 1;
      m_start_q = 0;
    end
  endtask

  task automatic model_tick();
    bit rise, hit;
    int nb[ML];
    int new_pend, c;
    rise = start && !m_start_q;
    m_start_q = start;
    m_step = 0;
    new_pend = m_pend;
    if (m_phase != 3 && di_req_valid && int'(di_req) != opposite(m_di)) new_pend = int'(di_req);
    case (m_phase)
      0: begin
        m_tick = 0;
        if (rise) m_phase = 1;
      end
      1: begin
        if (m_tick == TD - 1) begin
          m_tick = 0;
          for (int i = 0; i < ML; i++) nb[i] = int'(next_pos_num[i*NL +: NL]);
          hit = 0;
          for (int k = 1; k < m_len; k++) if (nb[k] == nb[0]) hit = 1;
          if (should_stop || hit) m_phase = 3;
          else begin
            m_body = nb;
            m_di = m_pend;
            m_step = 1;
            if (nb[0] == m_food) begin
              if (m_len < LEN_CAP) m_len++;
              if (m_score < 255) m_score++;
              m_phase = 2;
            end
          end
        end else m_tick++;
      end
      2: begin
        c = (m_lfsr < CELLS) ? m_lfsr : m_lfsr - CELLS;
        hit = 0;
        for (int i = 0; i < m_len; i++) if (m_body[i] == c) hit = 1;
        if (!hit) begin
          m_food = c;
          m_phase = 1;
        end
      end
      default: if (rise) begin
        model_init(0);
        new_pend = 1;
      end
    endcase
    m_pend = new_pend;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_init(1);
    else model_tick();
  end

  task automatic check(input string name, input logic [ML*NL-1:0] act, input logic [ML*NL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ML*NL-1:0] model_vec();
    logic [ML*NL-1:0] v;
    for (int i = 0; i < ML; i++) v[i*NL +: NL] = NL'(m_body[i]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("state", state, m_phase);
      check("di", di, m_di);
      check("len", len, m_len);
      check("pos_num", pos_num, model_vec());
      check("food_pos", food_pos, m_food);
      check("score", score, m_score);
      check("step", step, m_step);
    end
  end

  function automatic int seg(input int i);
    return int'(pos_num[i*NL +: NL]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; di_req_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic req(input logic [1:0] d);
    @(negedge clk); di_req = d; di_req_valid = 1'b1;
    @(negedge clk); di_req_valid = 1'b0;
  endtask

  task automatic wait_steps(input int n, input string name);
    int got = 0;
    for (int c = 0; c < 40 * n && got < n; c++) begin
      @(negedge clk);
      if (step) begin
        got++;
        stamps.push_back(cyc);
      end
    end
    check({name, "_steps_seen"}, got, n);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int c = 0;
    while (int'(state) != s && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, state, s);
  endtask

  task automatic wait_head(input int h, input int budget);
    int c = 0;
    while (seg(0) != h && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("reach_head", seg(0), h);
  endtask

  task automatic check_reinit(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_len"}, len, 5);
    check({tag, "_food"}, food_pos, 404);
    check({tag, "_score"}, score, 0);
    check({tag, "_di"}, di, 1);
    check({tag, "_seg0"}, seg(0), 388);
    check({tag, "_seg4"}, seg(4), 384);
    check({tag, "_seg5"}, seg(5), 10'h3FF);
  endtask

  initial begin
    model_init(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reinit("reset");
    check("reset_step", step, 0);

    // Three steps right, four cycles apart.
    stamps.delete();
    pulse_start();
    wait_steps(3, "first3");
    check("after3_head", seg(0), 391);
    check("after3_tail", seg(4), 387);
    if (stamps.size() == 3) begin
      check("step_gap1", stamps[1] - stamps[0], 4);
      check("step_gap2", stamps[2] - stamps[1], 4);
    end
    req(2'b00);
    wait_steps(1, "rev");
    check("rev_ignored_di", di, 1);
    check("rev_head", seg(0), 392);
    req(2'b11);
    wait_steps(1, "down_commit");
    check("down_di", di, 3);
    check("down_commit_head", seg(0), 393);
    wait_steps(1, "down_move");
    check("down_move_head", seg(0), 425);

    // Eat the first food, then run into the right wall.
    do_reset();
    pulse_start();
    wait_steps(16, "to_food");
    check("food_head", seg(0), 404);
    check("food_len", len, 6);
    check("food_score", score, 1);
    check("food_state", state, 2);
    wait_state(1, 40, "respawn_run");
    check("food_in_grid", food_pos < CELLS, 1);
    wait_head(415, 200);
    wait_state(3, 40, "wall_over");
    check("wall_head", seg(0), 415);
    repeat (10) @(negedge clk);
    check("wall_frozen_head", seg(0), 415);
    check("wall_frozen_state", state, 3);
    pulse_start();
    @(negedge clk);
    check_reinit("restart");

    // Self-collision: down, left, up from the start body.
    pulse_start();
    req(2'b11);
    wait_steps(1, "sc1");
    req(2'b00);
    wait_steps(1, "sc2");
    check("sc_head2", seg(0), 421);
    req(2'b10);
    wait_steps(1, "sc3");
    check("sc_head3", seg(0), 420);
    wait_state(3, 20, "self_over");
    check("self_head", seg(0), 420);

    // Random play with restarts and one asynchronous reset mid-game.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) start = ~start;
      di_req = 2'($urandom_range(0, 3));
      di_req_valid = ($urandom_range(0, 3) == 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_len", len, 5);
        check("async_step", step, 0);
        check("async_food", food_pos, 404);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    di_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
